// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants and types for the FP register file write-back controller
package fp_pkg;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;
  localparam int DATA_W   = 32;

  // One write-back request as seen at the register file port
  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } fwb_req_t;

  // Write-back source identity, used to remember who was granted last
  typedef enum logic {
    WB_FPU = 1'b0,
    WB_LD  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/f_regfile_wb_ctrl_if.sv
// rtl/f_regfile_wb_ctrl_if.sv - issue, write-back and register file port bundle
interface f_regfile_wb_ctrl_if;
  import fp_pkg::*;

  // Issue side
  logic              issue_valid;
  logic              issue_wr_f;
  logic [IDX_W-1:0]  issue_rd;
  logic [IDX_W-1:0]  issue_rs1;
  logic [IDX_W-1:0]  issue_rs2;
  logic [IDX_W-1:0]  issue_rs3;
  logic [2:0]        issue_rs_used;
  logic              issue_stall;

  // FPU result requester
  logic              fpu_wb_valid;
  logic [IDX_W-1:0]  fpu_wb_rd;
  logic [DATA_W-1:0] fpu_wb_data;
  logic              fpu_wb_ready;

  // Load result requester
  logic              ld_wb_valid;
  logic [IDX_W-1:0]  ld_wb_rd;
  logic [DATA_W-1:0] ld_wb_data;
  logic              ld_wb_ready;

  // Register file write port and status
  logic              rf_wb_en;
  logic [IDX_W-1:0]  rf_rd_index;
  logic [DATA_W-1:0] rf_wb_data;
  logic [NUM_REGS-1:0] busy_vec;
  logic              wb_err;

  // Controller side
  modport slave (
    input  issue_valid, issue_wr_f, issue_rd, issue_rs1, issue_rs2, issue_rs3, issue_rs_used,
    output issue_stall,
    input  fpu_wb_valid, fpu_wb_rd, fpu_wb_data,
    output fpu_wb_ready,
    input  ld_wb_valid, ld_wb_rd, ld_wb_data,
    output ld_wb_ready,
    output rf_wb_en, rf_rd_index, rf_wb_data, busy_vec, wb_err
  );

  // Decode/FPU/LSU side
  modport master (
    output issue_valid, issue_wr_f, issue_rd, issue_rs1, issue_rs2, issue_rs3, issue_rs_used,
    input  issue_stall,
    output fpu_wb_valid, fpu_wb_rd, fpu_wb_data,
    input  fpu_wb_ready,
    output ld_wb_valid, ld_wb_rd, ld_wb_data,
    input  ld_wb_ready,
    input  rf_wb_en, rf_rd_index, rf_wb_data, busy_vec, wb_err
  );

endinterface

// File: rtl/f_wb_rr_arbiter.sv
// rtl/f_wb_rr_arbiter.sv - two-requester round-robin arbiter for the FP write port
module f_wb_rr_arbiter
  import fp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_fpu_valid,
  input  logic i_ld_valid,
  output logic o_fpu_grant,
  output logic o_ld_grant
);

  // Starts as LD so the FPU wins the first conflict
  wb_src_e r_last_grant;

  // The port is free every cycle: a lone requester always wins, a conflict alternates
  always_comb begin
    o_fpu_grant = i_fpu_valid & (~i_ld_valid | (r_last_grant == WB_LD));
    o_ld_grant  = i_ld_valid  & (~i_fpu_valid | (r_last_grant == WB_FPU));
  end

  // Remember the winner; idle cycles leave the history untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= WB_LD;
    end else if (o_fpu_grant) begin
      r_last_grant <= WB_FPU;
    end else if (o_ld_grant) begin
      r_last_grant <= WB_LD;
    end
  end

endmodule

// File: rtl/f_regfile_wb_ctrl.sv
// rtl/f_regfile_wb_ctrl.sv - FP write-back arbitration, output stage and hazard scoreboard
module f_regfile_wb_ctrl #(
  parameter int NUM_REGS = fp_pkg::NUM_REGS,
  parameter int IDX_W    = fp_pkg::IDX_W,
  parameter int DATA_W   = fp_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  f_regfile_wb_ctrl_if.slave   bus
);
  import fp_pkg::*;

  logic                w_fpu_grant;
  logic                w_ld_grant;
  fwb_req_t            w_sel;
  logic                w_src_hit;
  logic                w_stall;
  logic                w_issue_fire;
  logic                w_err_hit;
  logic [NUM_REGS-1:0] w_busy_set;
  logic [NUM_REGS-1:0] w_busy_clr;
  logic [NUM_REGS-1:0] w_busy_nxt;

  logic [NUM_REGS-1:0] r_busy;
  logic                r_wb_en;
  logic [IDX_W-1:0]    r_rd_index;
  logic [DATA_W-1:0]   r_wb_data;
  logic                r_err;

  f_wb_rr_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_fpu_valid (bus.fpu_wb_valid),
    .i_ld_valid  (bus.ld_wb_valid),
    .o_fpu_grant (w_fpu_grant),
    .o_ld_grant  (w_ld_grant)
  );

  // Select the granted payload for the output stage
  always_comb begin
    w_sel = '0;
    if (w_fpu_grant) begin
      w_sel.valid = 1'b1;
      w_sel.rd    = bus.fpu_wb_rd;
      w_sel.data  = bus.fpu_wb_data;
    end else if (w_ld_grant) begin
      w_sel.valid = 1'b1;
      w_sel.rd    = bus.ld_wb_rd;
      w_sel.data  = bus.ld_wb_data;
    end
  end

  // Hazard detection and scoreboard next state; bit 0 is pinned clear since f0 reads as zero
  always_comb begin
    w_src_hit    = (bus.issue_rs_used[0] & r_busy[bus.issue_rs1])
                 | (bus.issue_rs_used[1] & r_busy[bus.issue_rs2])
                 | (bus.issue_rs_used[2] & r_busy[bus.issue_rs3]);
    w_stall      = bus.issue_valid & (w_src_hit | (bus.issue_wr_f & r_busy[bus.issue_rd]));
    w_issue_fire = bus.issue_valid & ~w_stall & bus.issue_wr_f & (bus.issue_rd != '0);
    w_busy_set   = w_issue_fire ? (NUM_REGS'(1) << bus.issue_rd) : '0;
    // Clear only from the registered write so a dependent cannot read before the RF update lands
    w_busy_clr   = r_wb_en ? (NUM_REGS'(1) << r_rd_index) : '0;
    w_busy_nxt   = ((r_busy & ~w_busy_clr) | w_busy_set) & ~NUM_REGS'(1);
    // A write-back to a register nobody is waiting on indicates a pipeline bookkeeping bug
    w_err_hit    = w_sel.valid & (w_sel.rd != '0) & ~r_busy[w_sel.rd];
  end

  // Output stage: one cycle between grant and register file write; idle keeps index/data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_en    <= 1'b0;
      r_rd_index <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_en <= w_sel.valid;
      if (w_sel.valid) begin
        r_rd_index <= w_sel.rd;
        r_wb_data  <= w_sel.data;
      end
    end
  end

  // Scoreboard and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_err_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.issue_stall  = w_stall;
  assign bus.fpu_wb_ready = w_fpu_grant;
  assign bus.ld_wb_ready  = w_ld_grant;
  assign bus.rf_wb_en     = r_wb_en;
  assign bus.rf_rd_index  = r_rd_index;
  assign bus.rf_wb_data   = r_wb_data;
  assign bus.busy_vec     = r_busy;
  assign bus.wb_err       = r_err;

endmodule

// File: tb/tb_f_regfile_wb_ctrl.sv
// tb/tb_f_regfile_wb_ctrl.sv - directed self-checking bench for f_regfile_wb_ctrl
module tb_f_regfile_wb_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  f_regfile_wb_ctrl_if bus();

  f_regfile_wb_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic wr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [2:0] used);
    bus.issue_valid   = v;
    bus.issue_wr_f    = wr;
    bus.issue_rd      = rd;
    bus.issue_rs1     = rs1;
    bus.issue_rs2     = 5'd0;
    bus.issue_rs3     = 5'd0;
    bus.issue_rs_used = used;
  endtask

  task automatic fpu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.fpu_wb_valid = v;
    bus.fpu_wb_rd    = rd;
    bus.fpu_wb_data  = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.ld_wb_valid = v;
    bus.ld_wb_rd    = rd;
    bus.ld_wb_data  = d;
  endtask

  initial begin
    issue(0, 0, 0, 0, 0);
    fpu(0, 0, 0);
    ld(0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state
    chk("rst_busy", bus.busy_vec, 0);
    chk("rst_en", bus.rf_wb_en, 0);
    chk("rst_idx", bus.rf_rd_index, 0);
    chk("rst_data", bus.rf_wb_data, 0);
    chk("rst_err", bus.wb_err, 0);
    chk("rst_stall", bus.issue_stall, 0);

    // 1: FMUL f5 marks busy, FADD reading f5 stalls
    tick();
    issue(1, 1, 5, 0, 3'b000);
    #1 chk("s1_fmul_stall", bus.issue_stall, 0);
    tick();
    chk("s1_busy", bus.busy_vec, 32'h20);
    issue(1, 1, 6, 5, 3'b001);
    #1 chk("s1_fadd_stall", bus.issue_stall, 1);
    tick();
    chk("s1_busy_held", bus.busy_vec, 32'h20);

    // 2: FPU write-back of f5, dependent FADD unstalls two cycles after grant
    fpu(1, 5, 32'h3F80_0000);
    #1 chk("s2_fpu_rdy", bus.fpu_wb_ready, 1);
    chk("s2_ld_rdy", bus.ld_wb_ready, 0);
    chk("s2_stall_n", bus.issue_stall, 1);
    tick();
    fpu(0, 5, 32'h3F80_0000);
    #1 chk("s2_en", bus.rf_wb_en, 1);
    chk("s2_idx", bus.rf_rd_index, 5);
    chk("s2_data", bus.rf_wb_data, 32'h3F80_0000);
    chk("s2_busy_n1", bus.busy_vec, 32'h20);
    chk("s2_stall_n1", bus.issue_stall, 1);
    tick();
    chk("s2_busy_n2", bus.busy_vec, 0);
    chk("s2_stall_n2", bus.issue_stall, 0);
    chk("s2_en_n2", bus.rf_wb_en, 0);
    chk("s2_idx_hold", bus.rf_rd_index, 5);
    tick();
    issue(0, 0, 0, 0, 0);
    chk("s2_fadd_busy", bus.busy_vec, 32'h40);

    // Lone load write-back of f6 (also leaves last grant at LD)
    ld(1, 6, 32'h4000_0000);
    #1 chk("ld6_rdy", bus.ld_wb_ready, 1);
    tick();
    ld(0, 6, 32'h4000_0000);
    #1 chk("ld6_idx", bus.rf_rd_index, 6);
    chk("ld6_data", bus.rf_wb_data, 32'h4000_0000);
    tick();
    chk("ld6_busy", bus.busy_vec, 0);

    // 3: pre-mark f1..f4, then both requesters valid for four cycles
    for (int r = 1; r <= 4; r++) begin
      issue(1, 1, 5'(r), 0, 3'b000);
      tick();
    end
    issue(0, 0, 0, 0, 0);
    chk("s3_busy", bus.busy_vec, 32'h1E);
    fpu(1, 1, 32'h11);
    ld(1, 3, 32'h33);
    #1 chk("s3_a_fpu", bus.fpu_wb_ready, 1);
    chk("s3_a_ld", bus.ld_wb_ready, 0);
    tick();
    fpu(1, 2, 32'h22);
    #1 chk("s3_b_fpu", bus.fpu_wb_ready, 0);
    chk("s3_b_ld", bus.ld_wb_ready, 1);
    chk("s3_b_idx", bus.rf_rd_index, 1);
    chk("s3_b_data", bus.rf_wb_data, 32'h11);
    tick();
    ld(1, 4, 32'h44);
    #1 chk("s3_c_fpu", bus.fpu_wb_ready, 1);
    chk("s3_c_ld", bus.ld_wb_ready, 0);
    chk("s3_c_idx", bus.rf_rd_index, 3);
    chk("s3_c_data", bus.rf_wb_data, 32'h33);
    tick();
    fpu(1, 2, 32'h222);
    #1 chk("s3_d_fpu", bus.fpu_wb_ready, 0);
    chk("s3_d_ld", bus.ld_wb_ready, 1);
    chk("s3_d_idx", bus.rf_rd_index, 2);
    chk("s3_d_data", bus.rf_wb_data, 32'h22);
    tick();
    fpu(0, 0, 0);
    ld(0, 0, 0);
    #1 chk("s3_e_en", bus.rf_wb_en, 1);
    chk("s3_e_idx", bus.rf_rd_index, 4);
    chk("s3_e_data", bus.rf_wb_data, 32'h44);
    tick();
    chk("s3_f_en", bus.rf_wb_en, 0);
    chk("s3_f_busy", bus.busy_vec, 0);
    chk("s3_f_err", bus.wb_err, 0);

    // 4: f0 never becomes busy and never causes a hazard
    issue(1, 1, 0, 0, 3'b000);
    #1 chk("s4_rd0_stall", bus.issue_stall, 0);
    tick();
    chk("s4_busy", bus.busy_vec, 0);
    issue(1, 1, 0, 0, 3'b111);
    #1 chk("s4_rs0_stall", bus.issue_stall, 0);
    tick();
    issue(0, 0, 0, 0, 0);
    chk("s4_busy2", bus.busy_vec, 0);

    // 5: load write-back to idle f7 flags a sticky error but still writes
    ld(1, 7, 32'h77);
    #1 chk("s5_rdy", bus.ld_wb_ready, 1);
    tick();
    ld(0, 0, 0);
    #1 chk("s5_err", bus.wb_err, 1);
    chk("s5_en", bus.rf_wb_en, 1);
    chk("s5_idx", bus.rf_rd_index, 7);
    tick();
    tick();
    chk("s5_err_sticky", bus.wb_err, 1);

    // 6: asynchronous reset with f4..f7 busy and a write in flight
    for (int r = 4; r <= 7; r++) begin
      issue(1, 1, 5'(r), 0, 3'b000);
      tick();
    end
    issue(0, 0, 0, 0, 0);
    chk("s6_busy", bus.busy_vec, 32'hF0);
    fpu(1, 4, 32'hAB);
    tick();
    fpu(0, 0, 0);
    #1 chk("s6_en_pre", bus.rf_wb_en, 1);
    #1 rst = 1'b1;
    #1 chk("s6_busy_rst", bus.busy_vec, 0);
    chk("s6_en_rst", bus.rf_wb_en, 0);
    chk("s6_err_rst", bus.wb_err, 0);
    chk("s6_idx_rst", bus.rf_rd_index, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("s6_post_busy", bus.busy_vec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
